// File: rtl/sevenseg_scan_decoder.sv
// ---------------------------------------------------------------------------------------------
// sevenseg_scan_decoder
//
// Monitors the receiving side of a 2-digit, time-multiplexed 7-segment display bus.
// The block recovers the hex value currently shown on each digit. It only captures the bus
// after {an_n, seg_n} has held still for STABLE_CYCLES consecutive samples. Scan transitions
// and ghosting therefore never reach the digit registers.
//
// Parameters:
//   STABLE_CYCLES  consecutive identical samples needed before a capture (legal 2..255)
//
// Ports:
//   clk          in   1  system clock, all state on rising edge
//   reset        in   1  asynchronous, active-high reset
//   an_n         in   2  anode select, active low (10 = digit 0, 01 = digit 1,
//                        11 = blank, 00 = conflict)
//   seg_n        in   7  segments, active low, bit0 = a .. bit6 = g
//   digit0       out  4  last valid hex value captured for digit 0
//   digit1       out  4  last valid hex value captured for digit 1
//   valid        out  2  bit i set once digit i has had a valid capture since reset
//   seg_err      out  2  bit i set if the latest capture for digit i was undecodable
//   an_conflict  out  1  sticky; set when anode value 00 is captured as stable
//   update       out  1  one-cycle pulse after any digit capture (hit or miss)
// ---------------------------------------------------------------------------------------------
module sevenseg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] an_n,
    input  logic [6:0] seg_n,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [1:0] valid,
    output logic [1:0] seg_err,
    output logic       an_conflict,
    output logic       update
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);

    // cnt saturates at STABLE_CYCLES; a capture fires when it reads STABLE_CYCLES-1 and the
    // current input still matches the sample.
    localparam logic [CntW-1:0] CntMax  = CntW'(STABLE_CYCLES);
    localparam logic [CntW-1:0] CntFire = CntW'(STABLE_CYCLES - 1);

    // The sample register resets to the idle bus (all anodes and segments off).
    localparam logic [8:0] SampleRst = {2'b11, 7'h7F};

    localparam logic [1:0] AnDigit0   = 2'b10;
    localparam logic [1:0] AnDigit1   = 2'b01;
    localparam logic [1:0] AnConflict = 2'b00;

    typedef enum logic [0:0] {
        StSettle,
        StHold
    } state_e;

    // ---------------------------------------------------------------------------------------
    // Segment decoder: active-high gfedcba pattern -> {hit, hex value}
    // ---------------------------------------------------------------------------------------
    function automatic logic [4:0] seg_decode(input logic [6:0] segs);
        logic [4:0] res;
        res = 5'b0_0000;
        case (segs)
            7'h3F:   res = {1'b1, 4'h0};
            7'h06:   res = {1'b1, 4'h1};
            7'h5B:   res = {1'b1, 4'h2};
            7'h4F:   res = {1'b1, 4'h3};
            7'h66:   res = {1'b1, 4'h4};
            7'h6D:   res = {1'b1, 4'h5};
            7'h7D:   res = {1'b1, 4'h6};
            7'h07:   res = {1'b1, 4'h7};
            7'h7F:   res = {1'b1, 4'h8};
            7'h6F:   res = {1'b1, 4'h9};
            7'h77:   res = {1'b1, 4'hA};
            7'h7C:   res = {1'b1, 4'hB};
            7'h39:   res = {1'b1, 4'hC};
            7'h5E:   res = {1'b1, 4'hD};
            7'h79:   res = {1'b1, 4'hE};
            7'h71:   res = {1'b1, 4'hF};
            default: res = 5'b0_0000;
        endcase
        return res;
    endfunction

    // ---------------------------------------------------------------------------------------
    // Input sampling and stability counter
    // ---------------------------------------------------------------------------------------
    logic [8:0]      bus;
    logic [8:0]      sample_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            same;

    assign bus  = {an_n, seg_n};
    assign same = (bus == sample_q);

    always_comb begin
        cnt_d = cnt_q;
        if (!same) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_q <= SampleRst;
            cnt_q    <= '0;
        end else begin
            sample_q <= bus;
            cnt_q    <= cnt_d;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Capture FSM: state register / next state / outputs
    // ---------------------------------------------------------------------------------------
    state_e state_q, state_d;
    logic   capture;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StSettle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSettle: begin
                if (same && (cnt_q == CntFire)) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                // Any change, even one segment, re-arms the stability window.
                if (!same) begin
                    state_d = StSettle;
                end
            end
            default: state_d = StSettle;
        endcase
    end

    always_comb begin
        capture = 1'b0;
        unique case (state_q)
            StSettle: capture = same && (cnt_q == CntFire);
            StHold:   capture = 1'b0;
            default:  capture = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------------------------------
    // Capture datapath
    // ---------------------------------------------------------------------------------------
    logic [4:0] dec;
    logic       dec_hit;
    logic [3:0] dec_val;
    logic       sel_d0, sel_d1, sel_conflict;

    // sample_q equals the live bus whenever capture is high, so decode from the register.
    assign dec          = seg_decode(~sample_q[6:0]);
    assign dec_hit      = dec[4];
    assign dec_val      = dec[3:0];
    assign sel_d0       = (sample_q[8:7] == AnDigit0);
    assign sel_d1       = (sample_q[8:7] == AnDigit1);
    assign sel_conflict = (sample_q[8:7] == AnConflict);

    logic [3:0] digit0_q, digit0_d;
    logic [3:0] digit1_q, digit1_d;
    logic [1:0] valid_q, valid_d;
    logic [1:0] seg_err_q, seg_err_d;
    logic       conflict_q, conflict_d;
    logic       update_q, update_d;

    always_comb begin
        digit0_d   = digit0_q;
        digit1_d   = digit1_q;
        valid_d    = valid_q;
        seg_err_d  = seg_err_q;
        conflict_d = conflict_q;
        update_d   = 1'b0;

        if (capture) begin
            if (sel_d0) begin
                update_d = 1'b1;
                if (dec_hit) begin
                    digit0_d   = dec_val;
                    valid_d[0] = 1'b1;
                end
                seg_err_d[0] = !dec_hit;
            end else if (sel_d1) begin
                update_d = 1'b1;
                if (dec_hit) begin
                    digit1_d   = dec_val;
                    valid_d[1] = 1'b1;
                end
                seg_err_d[1] = !dec_hit;
            end else if (sel_conflict) begin
                conflict_d = 1'b1;
            end
            // A blank bus (11) is captured silently: nothing changes.
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit0_q   <= 4'h0;
            digit1_q   <= 4'h0;
            valid_q    <= 2'b00;
            seg_err_q  <= 2'b00;
            conflict_q <= 1'b0;
            update_q   <= 1'b0;
        end else begin
            digit0_q   <= digit0_d;
            digit1_q   <= digit1_d;
            valid_q    <= valid_d;
            seg_err_q  <= seg_err_d;
            conflict_q <= conflict_d;
            update_q   <= update_d;
        end
    end

    assign digit0      = digit0_q;
    assign digit1      = digit1_q;
    assign valid       = valid_q;
    assign seg_err     = seg_err_q;
    assign an_conflict = conflict_q;
    assign update      = update_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// ---------------------------------------------------------------------------------------------
// tb_sevenseg_scan_decoder
//
// Directed bench for sevenseg_scan_decoder with STABLE_CYCLES = 4. Inputs are driven and
// outputs sampled 1 time unit after each rising edge. Expected values are hand-computed from
// the capture timing: an input change first seen at edge E0 is captured at edge E0 + 4.
// ---------------------------------------------------------------------------------------------
module tb_sevenseg_scan_decoder;

    logic       clk;
    logic       reset;
    logic [1:0] an_n;
    logic [6:0] seg_n;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [1:0] valid;
    logic [1:0] seg_err;
    logic       an_conflict;
    logic       update;

    int n_checks;
    int n_errors;

    sevenseg_scan_decoder #(
        .STABLE_CYCLES(4)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .digit0     (digit0),
        .digit1     (digit1),
        .valid      (valid),
        .seg_err    (seg_err),
        .an_conflict(an_conflict),
        .update     (update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance past one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance n edges, returning how many update pulses were seen.
    task automatic run(input int n, output int ups);
        ups = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (update === 1'b1) ups++;
        end
    endtask

    task automatic drive(input logic [1:0] an, input logic [6:0] seg);
        an_n  = an;
        seg_n = seg;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".digit0"}, 32'(digit0), 32'h0);
        check({tag, ".digit1"}, 32'(digit1), 32'h0);
        check({tag, ".valid"}, 32'(valid), 32'h0);
        check({tag, ".seg_err"}, 32'(seg_err), 32'h0);
        check({tag, ".an_conflict"}, 32'(an_conflict), 32'h0);
        check({tag, ".update"}, 32'(update), 32'h0);
    endtask

    initial begin
        int ups;
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        drive(2'b11, 7'h7F);

        // ---- Reset state, then first capture of '0' on digit 0 ----
        #12;
        check_all_zero("rst");
        reset = 1'b0;
        drive(2'b10, 7'h40);
        for (int i = 0; i <= 6; i++) begin
            step();
            check($sformatf("t1.update_e%0d", i), 32'(update), 32'(i == 4));
        end
        check("t1.digit0", 32'(digit0), 32'h0);
        check("t1.valid", 32'(valid), 32'h1);

        // ---- Alternating scan: '3' on digit 0, 'F' on digit 1, blanks between ----
        for (int r = 0; r < 2; r++) begin
            drive(2'b10, ~7'h4F);
            run(10, ups);
            check($sformatf("t2.ups_d0_r%0d", r), 32'(ups), 32'd1);
            drive(2'b11, 7'h7F);
            run(2, ups);
            check($sformatf("t2.ups_blank0_r%0d", r), 32'(ups), 32'd0);
            drive(2'b01, ~7'h71);
            run(10, ups);
            check($sformatf("t2.ups_d1_r%0d", r), 32'(ups), 32'd1);
            drive(2'b11, 7'h7F);
            run(2, ups);
            check($sformatf("t2.ups_blank1_r%0d", r), 32'(ups), 32'd0);
        end
        check("t2.digit0", 32'(digit0), 32'h3);
        check("t2.digit1", 32'(digit1), 32'hF);
        check("t2.valid", 32'(valid), 32'h3);

        // ---- Digit 1 with one segment toggling every 3 cycles, then a steady '8' ----
        ups = 0;
        for (int i = 0; i < 20; i++) begin
            drive(2'b01, (((i / 3) % 2) == 0) ? 7'h01 : 7'h00);
            step();
            if (update === 1'b1) ups++;
        end
        check("t3.ups_toggle", 32'(ups), 32'd0);
        check("t3.digit1_held", 32'(digit1), 32'hF);
        drive(2'b01, ~7'h7F);
        for (int i = 0; i <= 5; i++) begin
            step();
            check($sformatf("t3.update_e%0d", i), 32'(update), 32'(i == 4));
        end
        check("t3.digit1", 32'(digit1), 32'h8);

        // ---- Undecodable pattern on digit 0, then a valid '5' ----
        drive(2'b10, ~7'h01);
        run(8, ups);
        check("t4.ups_err", 32'(ups), 32'd1);
        check("t4.seg_err", 32'(seg_err), 32'h1);
        check("t4.digit0_held", 32'(digit0), 32'h3);
        check("t4.valid", 32'(valid), 32'h3);
        drive(2'b10, ~7'h6D);
        run(6, ups);
        check("t4.ups_ok", 32'(ups), 32'd1);
        check("t4.seg_err_clr", 32'(seg_err), 32'h0);
        check("t4.digit0", 32'(digit0), 32'h5);

        // ---- Anode conflict is sticky and never pulses update ----
        check("t5.conflict_pre", 32'(an_conflict), 32'h0);
        drive(2'b00, ~7'h6D);
        run(6, ups);
        check("t5.ups_conflict", 32'(ups), 32'd0);
        check("t5.conflict", 32'(an_conflict), 32'h1);
        check("t5.digit0_kept", 32'(digit0), 32'h5);
        drive(2'b10, ~7'h06);
        run(6, ups);
        check("t5.ups_after", 32'(ups), 32'd1);
        check("t5.digit0", 32'(digit0), 32'h1);
        check("t5.conflict_sticky", 32'(an_conflict), 32'h1);

        // ---- Async reset in the middle of a pending digit-1 capture ----
        drive(2'b01, ~7'h5B);
        run(3, ups); // cnt now 2
        check("t6.ups_pre", 32'(ups), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("t6.async");
        @(posedge clk);
        #2;
        reset = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            step();
            check($sformatf("t6.update_e%0d", i), 32'(update), 32'(i == 4));
        end
        check("t6.digit1", 32'(digit1), 32'h2);
        check("t6.valid", 32'(valid), 32'h2);
        check("t6.digit0", 32'(digit0), 32'h0);
        check("t6.conflict", 32'(an_conflict), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
